// File: rtl/ca_stream_checker.sv
// rtl/ca_stream_checker.sv - self-synchronising checker for the cellular-automaton PRNG word stream
module ca_stream_checker #(
    parameter int N        = 32,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  data_in,
    input  logic          data_valid,
    input  logic          resync,
    output logic          locked,
    output logic          error,
    output logic [CW-1:0] err_count,
    output logic [N-1:0]  expected
);

    localparam logic [7:0] LOCK_C = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_C = 8'(LOSS_CNT);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  pred_q, pred_d;
    logic [7:0]    match_cnt_q, match_cnt_d;
    logic [7:0]    miss_cnt_q, miss_cnt_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic          error_q, error_d;
    logic          locked_q, locked_d;

    logic          mismatch;
    logic [7:0]    match_inc;
    logic [7:0]    miss_inc;

    // One generation of the ring: lcr patterns 110, 101 and 000 produce a 1.
    function automatic logic [N-1:0] ca_step(input logic [N-1:0] v);
        logic [N-1:0] r;
        logic         l, c, rt;
        r = '0;
        for (int i = 0; i < N; i++) begin
            l    = v[(i + N - 1) % N];
            c    = v[i];
            rt   = v[(i + 1) % N];
            r[i] = (l & c & ~rt) | (l & ~c & rt) | (~l & ~c & ~rt);
        end
        return r;
    endfunction

    assign mismatch  = (data_in != pred_q);
    assign match_inc = match_cnt_q + 8'd1;
    assign miss_inc  = miss_cnt_q + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= HUNT;
            pred_q      <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_cnt_q   <= '0;
            error_q     <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_cnt_q   <= err_cnt_d;
            error_q     <= error_d;
            locked_q    <= locked_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (resync) begin
            state_d = HUNT;
        end else if (data_valid) begin
            case (state_q)
                HUNT:    state_d = CONFIRM;
                CONFIRM: if (!mismatch && match_inc == LOCK_C) state_d = LOCKED;
                LOCKED:  if (mismatch && miss_inc == LOSS_C) state_d = HUNT;
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        pred_d      = pred_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_cnt_d   = err_cnt_q;
        error_d     = 1'b0;
        if (resync) begin
            pred_d      = '0;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
            err_cnt_d   = '0;
        end else if (data_valid) begin
            case (state_q)
                HUNT: begin
                    pred_d      = ca_step(data_in);
                    match_cnt_d = '0;
                end
                CONFIRM: begin
                    // Every received word reseeds while acquiring, match or not.
                    pred_d      = ca_step(data_in);
                    match_cnt_d = mismatch ? 8'd0 : match_inc;
                    if (!mismatch && match_inc == LOCK_C) miss_cnt_d = '0;
                end
                LOCKED: begin
                    // Flywheel on our own prediction so corrupted words cannot steer it.
                    pred_d = ca_step(pred_q);
                    if (mismatch) begin
                        error_d    = 1'b1;
                        miss_cnt_d = miss_inc;
                        if (err_cnt_q != {CW{1'b1}}) err_cnt_d = err_cnt_q + CW'(1);
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: pred_d = pred_q;
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    assign locked    = locked_q;
    assign error     = error_q;
    assign err_count = err_cnt_q;
    assign expected  = pred_q;

endmodule

// File: tb/tb_ca_stream_checker.sv
// tb/tb_ca_stream_checker.sv - table and scoreboard bench for ca_stream_checker
module tb_ca_stream_checker;

    localparam int         LOCK = 2;
    localparam int         LOSS = 3;
    localparam logic [7:0] RULE = 8'h61;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [7:0]  a_data, b_data;
    logic        a_valid, a_resync, b_valid, b_resync;
    logic        a_locked, a_error, b_locked, b_error;
    logic [15:0] a_errcnt;
    logic [1:0]  b_errcnt;
    logic [7:0]  a_exp, b_exp;

    ca_stream_checker #(.N(8), .LOCK_CNT(2), .LOSS_CNT(3), .CW(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .data_in(a_data), .data_valid(a_valid),
        .resync(a_resync), .locked(a_locked), .error(a_error),
        .err_count(a_errcnt), .expected(a_exp));

    ca_stream_checker #(.N(8), .LOCK_CNT(2), .LOSS_CNT(5), .CW(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .data_in(b_data), .data_valid(b_valid),
        .resync(b_resync), .locked(b_locked), .error(b_error),
        .err_count(b_errcnt), .expected(b_exp));

    typedef struct {
        logic        valid;
        logic        resync;
        logic [7:0]  data;
        logic        locked;
        logic        error;
        logic [15:0] errcnt;
        logic [7:0]  expected;
    } vec_t;

    typedef struct {
        logic        locked;
        logic        error;
        logic [15:0] errcnt;
        logic [7:0]  expected;
        string       name;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    int          m_state, m_match, m_miss;
    logic [7:0]  m_pred;
    logic [15:0] m_cnt;
    logic        m_err;

    function automatic logic [7:0] ca_ref(input logic [7:0] v);
        logic [7:0] r;
        logic [2:0] idx;
        for (int i = 0; i < 8; i++) begin
            idx  = {v[(i + 7) % 8], v[i], v[(i + 1) % 8]};
            r[i] = RULE[idx];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pred = '0; m_match = 0; m_miss = 0; m_cnt = '0; m_err = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic rs, input logic [7:0] d);
        m_err = 1'b0;
        if (rs) begin
            model_reset();
        end else if (v) begin
            case (m_state)
                0: begin m_pred = ca_ref(d); m_match = 0; m_state = 1; end
                1: begin
                    if (d == m_pred) begin
                        m_match++;
                        if (m_match == LOCK) begin m_state = 2; m_miss = 0; end
                    end else begin
                        m_match = 0;
                    end
                    m_pred = ca_ref(d);
                end
                default: begin
                    if (d != m_pred) begin
                        m_err = 1'b1;
                        if (m_cnt != 16'hFFFF) m_cnt++;
                        m_miss++;
                        if (m_miss == LOSS) m_state = 0;
                    end else begin
                        m_miss = 0;
                    end
                    m_pred = ca_ref(m_pred);
                end
            endcase
        end
    endtask

    // Drive one cycle on dut_a; the expected record comes from the table row or the model.
    task automatic step_a(input logic v, input logic rs, input logic [7:0] d,
                          input logic use_row, input vec_t row, input string name);
        exp_t e;
        @(negedge clk);
        a_valid = v; a_resync = rs; a_data = d;
        model_step(v, rs, d);
        if (use_row) e = '{row.locked, row.error, row.errcnt, row.expected, name};
        else         e = '{(m_state == 2), m_err, m_cnt, m_pred, name};
        sb.push_back(e);
        @(posedge clk);
        #1;
        a_valid = 1'b0; a_resync = 1'b0;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.name, "_locked"},   {31'd0, a_locked}, {31'd0, e.locked});
            check({e.name, "_error"},    {31'd0, a_error},  {31'd0, e.error});
            check({e.name, "_errcnt"},   {16'd0, a_errcnt}, {16'd0, e.errcnt});
            check({e.name, "_expected"}, {24'd0, a_exp},    {24'd0, e.expected});
        end
    endtask

    task automatic run_a(input logic v, input logic rs, input logic [7:0] d, input string name);
        vec_t dummy;
        dummy = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 8'h00};
        step_a(v, rs, d, 1'b0, dummy, name);
    endtask

    task automatic step_b(input logic [7:0] d, input logic v, input logic el, input logic ee,
                          input logic [1:0] ec, input logic [7:0] ex, input string name);
        @(negedge clk);
        b_valid = v; b_resync = 1'b0; b_data = d;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        check({name, "_locked"},   {31'd0, b_locked}, {31'd0, el});
        check({name, "_error"},    {31'd0, b_error},  {31'd0, ee});
        check({name, "_errcnt"},   {30'd0, b_errcnt}, {30'd0, ec});
        check({name, "_expected"}, {24'd0, b_exp},    {24'd0, ex});
    endtask

    initial begin
        int         pulses;
        logic [7:0] w, p;

        reset_n = 1'b0;
        a_valid = 1'b0; a_resync = 1'b0; a_data = '0;
        b_valid = 1'b0; b_resync = 1'b0; b_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", {31'd0, a_locked}, 32'd0);
        check("rst_error",  {31'd0, a_error},  32'd0);
        check("rst_errcnt", {16'd0, a_errcnt}, 32'd0);
        check("rst_exp",    {24'd0, a_exp},    32'd0);
        check("rst_b_exp",  {24'd0, b_exp},    32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // valid, resync, data, locked, error, errcnt, expected
        tbl.push_back('{1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 16'd0, 8'h7C});
        tbl.push_back('{1'b1, 1'b0, 8'h7C, 1'b0, 1'b0, 16'd0, 8'h41});
        tbl.push_back('{1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 16'd0, 8'h9C});
        tbl.push_back('{1'b1, 1'b0, 8'h9C, 1'b1, 1'b0, 16'd0, 8'h10});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 16'd1, 8'hC7});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'd1, 8'hC7});
        tbl.push_back('{1'b1, 1'b1, 8'hC7, 1'b0, 1'b0, 16'd0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 16'd0, 8'h7C});
        tbl.push_back('{1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 16'd0, 8'hAA});
        tbl.push_back('{1'b1, 1'b0, 8'h7C, 1'b0, 1'b0, 16'd0, 8'h41});
        tbl.push_back('{1'b1, 1'b0, 8'h41, 1'b0, 1'b0, 16'd0, 8'h9C});
        tbl.push_back('{1'b1, 1'b0, 8'h9C, 1'b1, 1'b0, 16'd0, 8'h10});
        for (int i = 0; i < tbl.size(); i++)
            step_a(tbl[i].valid, tbl[i].resync, tbl[i].data, 1'b1, tbl[i], $sformatf("tbl%0d", i));

        // Loss of lock: three wrong words in a row.
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            run_a(1'b1, 1'b0, ~m_pred, $sformatf("loss%0d", i));
            if (a_error) pulses++;
        end
        check("loss_pulses", pulses, 32'd3);
        check("loss_errcnt", {16'd0, a_errcnt}, 32'd3);
        check("loss_locked", {31'd0, a_locked}, 32'd0);
        run_a(1'b1, 1'b0, 8'h01, "hunt_seed");
        check("hunt_seed_exp", {24'd0, a_exp}, 32'h7C);

        // Relock, then a 5-cycle gap, then correct words.
        run_a(1'b1, 1'b0, 8'h7C, "relock0");
        run_a(1'b1, 1'b0, 8'h41, "relock1");
        for (int i = 0; i < 5; i++) run_a(1'b0, 1'b0, 8'hFF, $sformatf("gap%0d", i));
        run_a(1'b1, 1'b0, m_pred, "gap_good0");
        run_a(1'b1, 1'b0, m_pred, "gap_good1");
        run_a(1'b1, 1'b0, ~m_pred, "pre_resync_err");
        run_a(1'b1, 1'b1, m_pred, "resync_valid");
        check("resync_locked", {31'd0, a_locked}, 32'd0);
        check("resync_errcnt", {16'd0, a_errcnt}, 32'd0);
        check("resync_exp",    {24'd0, a_exp},    32'd0);

        // Asynchronous reset while locked.
        run_a(1'b1, 1'b0, 8'h01, "rl0");
        run_a(1'b1, 1'b0, 8'h7C, "rl1");
        run_a(1'b1, 1'b0, 8'h41, "rl2");
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_locked", {31'd0, a_locked}, 32'd0);
        check("async_rst_exp",    {24'd0, a_exp},    32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Random mix of correct words, corrupted words, gaps and resyncs.
        for (int i = 0; i < 300; i++) begin
            p = m_pred;
            case ($urandom_range(9))
                0, 1:    w = 8'($urandom);
                2:       w = p ^ 8'h01;
                default: w = p;
            endcase
            run_a(($urandom_range(4) != 0), ($urandom_range(40) == 0), w, $sformatf("rnd%0d", i));
        end

        // Error counter saturation on the narrow-counter instance.
        step_b(8'h01, 1'b1, 1'b0, 1'b0, 2'd0, 8'h7C, "sat_l0");
        step_b(8'h7C, 1'b1, 1'b0, 1'b0, 2'd0, 8'h41, "sat_l1");
        step_b(8'h41, 1'b1, 1'b1, 1'b0, 2'd0, 8'h9C, "sat_l2");
        pulses = 0;
        p = 8'h9C;
        for (int i = 0; i < 4; i++) begin
            p = ca_ref(p);
            step_b(8'h00, 1'b1, 1'b1, 1'b1, (i < 3) ? 2'(i + 1) : 2'd3, p, $sformatf("sat_m%0d", i));
            if (b_error) pulses++;
        end
        check("sat_pulses", pulses, 32'd4);
        step_b(8'h00, 1'b0, 1'b1, 1'b0, 2'd3, p, "sat_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ca_stream_checker.md
Name: ca_stream_checker

Overview:
- Receive-side companion to the team's cellular-automaton PRNG generator.
- Accepts the generator's word stream, self-synchronises by seeding its own CA copy from received words, and predicts each next word.
- Declares lock after consecutive correct predictions, then flags and counts mismatches.
- Used in loopback/BIST paths to verify PRNG streams crossing links or FIFOs.

Parameters:
- N, 32, word width; CA ring length.
- LOCK_CNT, 4, consecutive matches in CONFIRM needed to declare lock (1..255).
- LOSS_CNT, 3, consecutive mismatches in LOCKED that drop lock (1..255).
- CW, 16, width of the error counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- data_in  in  N  received PRNG word.
- data_valid  in  1  data_in valid this cycle; no backpressure, so a word is accepted every valid cycle.
- resync  in  1  synchronous restart of acquisition; clears all counters.
- locked  out  1  registered; high while in LOCKED.
- error  out  1  registered one-cycle pulse on a mismatch while LOCKED.
- err_count  out  CW  registered saturating count of LOCKED mismatches.
- expected  out  N  registered current prediction register.

Behaviour:
- Update function F(v): cell i uses neighbours l=v[(i+N-1)%N], c=v[i], r=v[(i+1)%N].
  - F(v)[i] = (l&c&~r) | (l&~c&r) | (~l&~c&~r).
  - Patterns lcr = 110, 101 and 000 give 1; all others give 0. The ring wraps at both ends.
- Reset (async assert; synchronous release on the next clk):
  - state=HUNT, pred=0, match_cnt=0, miss_cnt=0.
  - Outputs: locked=0, error=0, err_count=0, expected=0.
- All state advances only on cycles with data_valid=1, except resync.
- HUNT, valid word w: pred<=F(w), match_cnt<=0, go to CONFIRM. No compare, no error.
- CONFIRM, valid word w:
  - If w==pred: match_cnt+1, pred<=F(w). When the incremented count equals LOCK_CNT, go to LOCKED and clear miss_cnt.
  - If w!=pred: match_cnt<=0, pred<=F(w) (reseed), stay in CONFIRM. error stays 0.
- LOCKED, valid word w:
  - Flywheel: pred<=F(pred) whether or not w matches. Received data never reseeds while locked.
  - If w==pred: miss_cnt<=0.
  - If w!=pred: error pulses 1 on the next cycle; err_count+1, saturating at all-ones; miss_cnt+1.
  - If the incremented miss_cnt equals LOSS_CNT: go to HUNT, with locked=0 from the next cycle. The mismatch that triggers loss is still counted and flagged.
- Latency:
  - locked, error, err_count and expected update one clk after the accepting edge, i.e. they are visible in the cycle following the valid word.
  - error is 0 on every cycle without a LOCKED mismatch, including cycles with data_valid=0.
- resync=1 at a clk edge:
  - Next state is HUNT; pred, match_cnt, miss_cnt and err_count clear; locked=0, error=0.
  - resync has priority over a simultaneous data_valid; that word is discarded.
- Reset mid-stream: all state is lost and acquisition restarts from HUNT. No partial lock survives.
- data_valid=0: all registers hold.
- Degenerate values: F(all-zero)=all-ones and F(all-ones)=all-zero, so no special handling is needed.
- Counter widths: match_cnt and miss_cnt are 8 bits. err_count never wraps.

Test Plan:
- Vectors use N=8.
- Lock acquisition (LOCK_CNT=2, LOSS_CNT=3), valid words 0x01, 0x7C, 0x41 back-to-back -> after 0x01 expected=0x7C; after 0x7C expected=0x41; locked=1 the cycle after 0x41, with expected=0x9C; error never asserted.
- Locked error (continue from the previous scenario), send 0x9C then 0x00 -> after 0x9C expected=0x10, no error; after 0x00 error=1 for one cycle, err_count=1, expected=F(0x10), locked stays 1.
- Loss of lock: after locking, send 3 consecutive wrong words -> error pulses 3 times, err_count=3, locked falls the cycle after the third; the next word seeds HUNT.
- CONFIRM reseed (LOCK_CNT=2): 0x01, 0x55 (wrong), 0x7C -> no lock and no error; 0x55 reseeds with expected=F(0x55)=0xAA, and 0x7C mismatches and reseeds again.
- Gaps and resync:
  - Locked stream with data_valid low for 5 cycles between words -> registers hold, no error.
  - resync asserted together with data_valid -> next cycle locked=0, err_count=0, and the word is ignored.
- Saturation (CW=2): lock, then force 4 mismatches with LOSS_CNT=5 -> err_count sticks at 3 and error pulses 4 times.
